prbs_word_arbiter: RTL and testbench

//  Shares one 16-bit Galois LFSR between NREQ requesters.
//  - Round-robin arbiter grants one requester at a time.
//  - Controller clocks the LFSR OUT_W times, serialises the bits into a word and returns it over a valid/ready handshake.
//  - Also owns seeding of the LFSR. Sits between the PRNG and test/scrambler clients.

---
 rtl/prbs_word_arbiter.sv | 179 +++++++++++++++++
 tb/tb_prbs_word_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_word_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prbs_word_arbiter: round-robin shared 16-bit Galois LFSR word generator   |
// | Option macro: LFSR_ZERO_GUARD_EN (keeps the LFSR out of the all-zero state)|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module prbs_word_arbiter #(
  parameter int          NREQ  = 4,
  parameter int          OUT_W = 8,
  parameter logic [15:0] TAPS  = 16'hB400,
  parameter logic [15:0] SEED  = 16'h0001
) (
  input  logic                    clk,
  input  logic                    _rst,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         gnt,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [OUT_W-1:0]        rsp_data,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  input  logic                    seed_load,
  input  logic [15:0]             seed_value,
  output logic                    seed_err,
  output logic [15:0]             lfsr_state
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(OUT_W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GEN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             serr_q, serr_d;

  logic [15:0]      w_lfsr_step;
  logic [15:0]      w_seed;
  logic             w_bit;
  logic [OUT_W-1:0] w_data_shift;
  logic             w_found;
  logic             w_hi_found;
  logic [IDW-1:0]   w_hi;
  logic [IDW-1:0]   w_lo;
  logic [IDW-1:0]   w_winner;
  logic [IDW-1:0]   w_ptr_next;

  always_comb begin
    w_bit       = lfsr_q[0];
    w_lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 16'h0000);
`ifdef LFSR_ZERO_GUARD_EN
    if (lfsr_q == 16'h0000) begin
      w_lfsr_step = 16'h0001;
    end
    w_seed = (seed_value == 16'h0000) ? 16'h0001 : seed_value;
`else
    w_seed = seed_value;
`endif
  end

  // First generated bit must end up at the MSB after OUT_W shifts.
  generate
    if (OUT_W == 1) begin : g_shift_single
      assign w_data_shift = w_bit;
    end else begin : g_shift_multi
      assign w_data_shift = {data_q[OUT_W-2:0], w_bit};
    end
  endgenerate

  // Lowest request at/above the pointer wins, else lowest request overall.
  always_comb begin
    w_found    = 1'b0;
    w_hi_found = 1'b0;
    w_hi       = '0;
    w_lo       = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        w_found = 1'b1;
        w_lo    = IDW'(j);
        if (IDW'(j) >= ptr_q) begin
          w_hi_found = 1'b1;
          w_hi       = IDW'(j);
        end
      end
    end
    w_winner = w_hi_found ? w_hi : w_lo;
  end

  assign w_ptr_next = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    serr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (seed_load) begin
          lfsr_d = w_seed;
        end else if (w_found) begin
          state_d = S_GEN;
          gnt_d   = NREQ'(1) << w_winner;
          id_d    = w_winner;
          cnt_d   = '0;
        end
      end
      S_GEN: begin
        serr_d = seed_load;
        lfsr_d = w_lfsr_step;
        data_d = w_data_shift;
        if (cnt_q == CW'(OUT_W - 1)) begin
          state_d = S_DONE;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        serr_d = seed_load;
        if (rsp_ready) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          valid_d = 1'b0;
          ptr_d   = w_ptr_next;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      ptr_q   <= '0;
      id_q    <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      serr_q  <= serr_d;
    end
  end

  assign gnt        = gnt_q;
  assign rsp_valid  = valid_q;
  assign rsp_data   = data_q;
  assign rsp_id     = id_q;
  assign seed_err   = serr_q;
  assign lfsr_state = lfsr_q;

endmodule
`default_nettype wire

// File: tb/tb_prbs_word_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_prbs_word_arbiter: directed self-checking bench for prbs_word_arbiter  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_prbs_word_arbiter;

  logic        clk;
  logic        _rst;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        seed_load;
  logic [15:0] seed_value;
  logic        seed_err;
  logic [15:0] lfsr_state;

  int checks   = 0;
  int failures = 0;

  prbs_word_arbiter #(
    .NREQ (4),
    .OUT_W(8),
    .TAPS (16'hB400),
    .SEED (16'h0001)
  ) dut (
    .clk       (clk),
    ._rst      (_rst),
    .req       (req),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .seed_load (seed_load),
    .seed_value(seed_value),
    .seed_err  (seed_err),
    .lfsr_state(lfsr_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check_eq("valid_seen", {31'b0, rsp_valid}, 32'd1);
  endtask

  task automatic do_reset();
    _rst = 1'b0;
    tick();
    tick();
    _rst = 1'b1;
  endtask

  int         n;
  int         ngr;
  bit         onehot_ok;
  logic [3:0] prev;
  int         order [5];
  int         ids   [5];
  int         stamp [5];
  int         idx;
  logic [7:0] zero_word;

  initial begin
    _rst = 1'b0; req = '0; rsp_ready = 1'b0; seed_load = 1'b0; seed_value = '0;
    tick();
    tick();
    check_eq("rst_gnt",   {28'b0, gnt}, 32'h0);
    check_eq("rst_valid", {31'b0, rsp_valid}, 32'h0);
    check_eq("rst_data",  {24'b0, rsp_data}, 32'h0);
    check_eq("rst_id",    {30'b0, rsp_id}, 32'h0);
    check_eq("rst_serr",  {31'b0, seed_err}, 32'h0);
    check_eq("rst_lfsr",  {16'b0, lfsr_state}, 32'h0001);

    // Test 1: first word from SEED
    _rst = 1'b1;
    req  = 4'b0001;
    tick();
    check_eq("t1_gnt", {28'b0, gnt}, 32'h1);
    check_eq("t1_valid_early", {31'b0, rsp_valid}, 32'h0);
    wait_valid(50, n);
    check_eq("t1_latency", n, 32'd8);
    check_eq("t1_data", {24'b0, rsp_data}, 32'h80);
    check_eq("t1_id",   {30'b0, rsp_id}, 32'h0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("t1_gnt_after", {28'b0, gnt}, 32'h0);
    check_eq("t1_valid_after", {31'b0, rsp_valid}, 32'h0);
    check_eq("t1_lfsr", {16'b0, lfsr_state}, 32'h0168);

    // Test 2: second word, req still held
    wait_valid(50, n);
    check_eq("t2_latency", n, 32'd9);
    check_eq("t2_data", {24'b0, rsp_data}, 32'h16);
    check_eq("t2_lfsr", {16'b0, lfsr_state}, 32'h7C41);
    rsp_ready = 1'b1;
    req       = 4'b0000;
    tick();
    rsp_ready = 1'b0;
    check_eq("t2_lfsr_after", {16'b0, lfsr_state}, 32'h7C41);

    // Test 3: round-robin order under full load
    do_reset();
    req = 4'b1111; rsp_ready = 1'b1;
    prev = '0; ngr = 0; onehot_ok = 1'b1;
    for (int c = 0; c < 120 && ngr < 5; c++) begin
      tick();
      if (gnt != 4'b0 && (gnt & (gnt - 4'd1)) != 4'b0) onehot_ok = 1'b0;
      if (gnt != 4'b0 && prev == 4'b0) begin
        idx = 0;
        for (int b = 0; b < 4; b++) if (gnt[b]) idx = b;
        order[ngr] = idx;
        ids[ngr]   = int'(rsp_id);
        stamp[ngr] = c;
        ngr++;
      end
      prev = gnt;
    end
    req = 4'b0000;
    check_eq("t3_grant_count", ngr, 32'd5);
    check_eq("t3_onehot", {31'b0, onehot_ok}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("t3_order%0d", k), order[k], k % 4);
      check_eq($sformatf("t3_id%0d", k), ids[k], k % 4);
    end
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("t3_spacing%0d", k), stamp[k+1] - stamp[k], 32'd10);
    end
    n = 0;
    while (gnt != 4'b0 && n < 30) begin
      tick();
      n++;
    end
    check_eq("t3_drain", {28'b0, gnt}, 32'h0);
    rsp_ready = 1'b0;

    // Test 4: backpressure in DONE with request dropped
    do_reset();
    req = 4'b0010;
    wait_valid(50, n);
    check_eq("t4_data", {24'b0, rsp_data}, 32'h80);
    check_eq("t4_id",   {30'b0, rsp_id}, 32'h1);
    req = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq($sformatf("t4_valid%0d", k), {31'b0, rsp_valid}, 32'd1);
      check_eq($sformatf("t4_data%0d", k), {24'b0, rsp_data}, 32'h80);
      check_eq($sformatf("t4_gnt%0d", k), {28'b0, gnt}, 32'h2);
      check_eq($sformatf("t4_lfsr%0d", k), {16'b0, lfsr_state}, 32'h0168);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("t4_gnt_after", {28'b0, gnt}, 32'h0);
    check_eq("t4_valid_after", {31'b0, rsp_valid}, 32'h0);

    // Test 5: seed_load during GEN is rejected
    req = 4'b0100;
    tick();
    check_eq("t5_gnt", {28'b0, gnt}, 32'h4);
    req = 4'b0000; seed_load = 1'b1; seed_value = 16'h1234;
    tick();
    seed_load = 1'b0;
    check_eq("t5_serr_hi", {31'b0, seed_err}, 32'd1);
    tick();
    check_eq("t5_serr_lo", {31'b0, seed_err}, 32'd0);
    wait_valid(50, n);
    check_eq("t5_data", {24'b0, rsp_data}, 32'h16);
    check_eq("t5_lfsr", {16'b0, lfsr_state}, 32'h7C41);
    check_eq("t5_id",   {30'b0, rsp_id}, 32'h2);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    // seed and request in the same IDLE cycle: seed wins
    seed_load = 1'b1; seed_value = 16'h0001; req = 4'b1000;
    tick();
    seed_load = 1'b0;
    check_eq("t5_seed_nogrant", {28'b0, gnt}, 32'h0);
    check_eq("t5_seed_lfsr", {16'b0, lfsr_state}, 32'h0001);
    check_eq("t5_seed_noerr", {31'b0, seed_err}, 32'd0);
    tick();
    check_eq("t5_late_gnt", {28'b0, gnt}, 32'h8);
    wait_valid(50, n);
    check_eq("t5_reseed_data", {24'b0, rsp_data}, 32'h80);
    check_eq("t5_reseed_id", {30'b0, rsp_id}, 32'h3);
    // pointer wraps from 3 to 0
    rsp_ready = 1'b1; req = 4'b1001;
    tick();
    rsp_ready = 1'b0;
    tick();
    check_eq("t5_wrap_gnt", {28'b0, gnt}, 32'h1);

    // Test 6: asynchronous reset mid-GEN
    tick();
    tick();
    tick();
    _rst = 1'b0;
    #1;
    check_eq("t6_rst_gnt",   {28'b0, gnt}, 32'h0);
    check_eq("t6_rst_valid", {31'b0, rsp_valid}, 32'h0);
    check_eq("t6_rst_data",  {24'b0, rsp_data}, 32'h0);
    check_eq("t6_rst_id",    {30'b0, rsp_id}, 32'h0);
    check_eq("t6_rst_lfsr",  {16'b0, lfsr_state}, 32'h0001);
    req = 4'b0000;
    tick();
    _rst = 1'b1;

    // Test 6: zero seed
    seed_load = 1'b1; seed_value = 16'h0000;
    tick();
    seed_load = 1'b0;
`ifdef LFSR_ZERO_GUARD_EN
    check_eq("t6_zero_lfsr", {16'b0, lfsr_state}, 32'h0001);
    zero_word = 8'h80;
`else
    check_eq("t6_zero_lfsr", {16'b0, lfsr_state}, 32'h0000);
    zero_word = 8'h00;
`endif
    req = 4'b0001;
    tick();
    req = 4'b0000;
    wait_valid(50, n);
    check_eq("t6_zero_word", {24'b0, rsp_data}, {24'b0, zero_word});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("t6_zero_done", {31'b0, rsp_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
